// File: rtl/rams_pkg.sv
// rtl/rams_pkg.sv - shared constants and init FSM state type for the single-port RAM family
package rams_pkg;

    localparam int RAM_READ_FIRST  = 0;
    localparam int RAM_WRITE_FIRST = 1;
    localparam int RAM_NO_CHANGE   = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_init_state_t;

endpackage

// File: rtl/ram_init_seq.sv
// rtl/ram_init_seq.sv - post-reset sequencer that walks every address once to load the init value
module ram_init_seq
    import rams_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              init_busy_o,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o
);

    // One extra counter bit so the count can step past the last address without wrapping to 0.
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    ram_init_state_t   state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // State and address counter register; reset restarts the sweep from address 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: write one word per cycle while in INIT, leave after the last address.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_o = 1'b0;
        if (state_q == INIT) begin
            init_we_o = !rst_i;
            cnt_d     = cnt_q + (ADDR_W+1)'(1);
            if (cnt_q == LAST_CNT) begin
                state_d = RUN;
            end
        end
    end

    assign init_busy_o = (state_q == INIT);
    assign init_addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/rams_sp_gen.sv
// rtl/rams_sp_gen.sv - single-port byte-write RAM with init sequencer; RAMS_SP_OUTREG_EN adds a 2nd output stage
module rams_sp_gen
    import rams_pkg::*;
#(
    parameter int                  DATA_W   = 16,
    parameter int                  ADDR_W   = 6,
    parameter int                  BYTE_W   = 8,
    parameter int                  MODE     = 0,
    parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [DATA_W/BYTE_W-1:0]   we_i,
    input  logic [ADDR_W-1:0]          a_i,
    input  logic [DATA_W-1:0]          di_i,
    output logic [DATA_W-1:0]          do_o,
    output logic                       do_valid_o,
    output logic                       init_busy_o
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_busy;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    logic              user_acc;
    logic [NB-1:0]     wr_lanes;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] merged;

    logic [DATA_W-1:0] do1_q, do1_d;
    logic              dv1_q, dv1_d;

    ram_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .init_busy_o (init_busy),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    // The user port is only live in RUN and never on a reset cycle.
    assign user_acc = en_i && !init_busy && !rst_i;
    assign rd_old   = mem[a_i];

    // Write-port mux: the sequencer owns the array during init, the user port afterwards.
    always_comb begin
        wr_lanes = '0;
        wr_addr  = a_i;
        wr_data  = di_i;
        if (init_we) begin
            wr_lanes = '1;
            wr_addr  = init_addr;
            wr_data  = INIT_VAL;
        end else if (user_acc) begin
            wr_lanes = we_i;
        end
    end

    // Inferable byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_lanes[i]) begin
                mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Word as it will look after this access, used for write-first read data.
    always_comb begin
        merged = rd_old;
        for (int i = 0; i < NB; i++) begin
            if (we_i[i]) begin
                merged[i*BYTE_W +: BYTE_W] = di_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read-data selection by read-during-write mode; a no-change write neither updates nor validates.
    always_comb begin
        do1_d = do1_q;
        dv1_d = user_acc && !((MODE == RAM_NO_CHANGE) && (|we_i));
        if (user_acc) begin
            if (MODE == RAM_WRITE_FIRST) begin
                do1_d = merged;
            end else if (MODE == RAM_NO_CHANGE) begin
                if (we_i == '0) begin
                    do1_d = rd_old;
                end
            end else begin
                do1_d = rd_old;
            end
        end
    end

    // First output register stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            do1_q <= '0;
            dv1_q <= 1'b0;
        end else begin
            do1_q <= do1_d;
            dv1_q <= dv1_d;
        end
    end

`ifdef RAMS_SP_OUTREG_EN
    logic [DATA_W-1:0] do2_q;
    logic              dv2_q;

    // Second output stage simply delays stage 1 by one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            do2_q <= '0;
            dv2_q <= 1'b0;
        end else begin
            do2_q <= do1_q;
            dv2_q <= dv1_q;
        end
    end

    assign do_o       = do2_q;
    assign do_valid_o = dv2_q;
`else
    assign do_o       = do1_q;
    assign do_valid_o = dv1_q;
`endif

    assign init_busy_o = init_busy;

endmodule
